imem_load_controller: RTL and testbench
=======================================

Name: imem_load_controller

Overview:
- Sequences access to the single-port instruction memory (async read, sync write, word-addressed via byte_address[9:2]).
- Shares that memory between the core's fetch stage (read-only) and a boot/debug loader that streams 32-bit instruction words in.
- Holds the core in reset while a program is loaded, then hands the memory to fetch.
- Supports a software/debug-requested reload without a chip reset.

Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory (power of 2).
- LOAD_BASE, 32'h0000_0000, byte address of the first loaded word (word-aligned).
- AW, $clog2(DEPTH), word-counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fetch_req  input  1  fetch stage requests a read.
- fetch_addr  input  32  fetch byte address.
- fetch_data  output  32  instruction word returned.
- fetch_valid  output  1  fetch_data valid this cycle.
- ld_valid  input  1  loader presents a word.
- ld_data  input  32  instruction word to write.
- ld_last  input  1  qualifies final word of the image.
- ld_ready  output  1  controller accepts the word this cycle.
- reload_req  input  1  single-cycle pulse: request a new load while running.
- core_hold  output  1  keeps the core in reset / stalled.
- load_done  output  1  level, image loaded and core released.
- load_error  output  1  sticky, image overflowed DEPTH.
- words_loaded  output  AW+1  count of words written in the last/current load.
- mem_byte_address  output  32  to memory byte_address.
- mem_write_enable  output  1  to memory write_enable.
- mem_write_data  output  32  to memory write_data.
- mem_read_data  input  32  from memory read_data.

Behaviour:
- Reset values:
  - state=LOAD, core_hold=1, ld_ready=0, fetch_valid=0, load_done=0, load_error=0.
  - words_loaded=0, word pointer=0, mem_write_enable=0.
  - mem_byte_address=LOAD_BASE.
- States LOAD, RUN, DRAIN. State, pointer and counters are registered; memory-side outputs are combinational from state and inputs.
- LOAD:
  - ld_ready=1, core_hold=1, fetch_valid=0.
  - mem_byte_address=LOAD_BASE+{ptr,2'b00}.
  - mem_write_enable=ld_valid, mem_write_data=ld_data.
  - On accept (ld_valid&ld_ready), the write commits at that edge; ptr and words_loaded increment.
- LOAD exits:
  - Accept with ld_last=1 -> RUN next cycle.
  - Accept of word DEPTH-1 with ld_last=0 -> RUN, load_error set. Word still written, pointer wraps to 0, no further writes.
  - ld_valid=0 stalls indefinitely; no timeout.
- RUN:
  - core_hold=0, load_done=1, ld_ready=0, mem_write_enable=0.
  - mem_byte_address=fetch_addr, fetch_data=mem_read_data.
  - fetch_valid=fetch_req, zero latency (same cycle, async read).
  - ld_valid is ignored in RUN.
- reload_req in RUN -> DRAIN.
- DRAIN (exactly one cycle):
  - core_hold=1, fetch_valid=0, ld_ready=0.
  - Then -> LOAD with ptr=0, words_loaded=0, load_done=0. load_error is kept.
- reload_req in LOAD or DRAIN is ignored.
- reload_req and fetch_req in the same RUN cycle: that fetch still completes (fetch_valid=1); DRAIN follows.
- load_error clears only on reset_n.
- fetch_addr is unmasked. Aliasing beyond DEPTH words is the memory's behaviour; this block does not check it.
- reset_n asserted mid-load: immediate return to LOAD with pointer 0. Partially written memory contents are not erased.
- Never more than one write per cycle. A write and a fetch never occur in the same cycle.

Decomposition:
- Shared package imem_pkg:
  - ctrl_state_t enum {LOAD, RUN, DRAIN}.
  - IMEM_DEPTH=256, WORD_BYTES=4, NOP_INSTR=32'h0000_0013.
- No sub-module is needed. FSM and pointer live in one always_ff; the memory mux lives in one always_comb.

Test Plan:
- Reset, then stream 6 words (NOP, 32'h00100093, 32'h00200113, 32'h00300193, 32'h00408213, 32'h002182B3), ld_last on the 6th:
  - Writes go to addresses 0x0..0x14.
  - words_loaded=6; core_hold falls 1 cycle after the last accept; load_done=1.
- RUN, fetch_req=1 at fetch_addr=0x10 -> fetch_valid=1 the same cycle, fetch_data=32'h00408213, mem_write_enable=0.
- ld_valid pulsed with gaps (1,0,0,1,1) in LOAD:
  - Exactly 3 writes at consecutive addresses.
  - ld_ready=1 throughout, no skipped addresses.
- Stream 256 words with no ld_last:
  - Last write at 0x3FC, load_error=1, words_loaded=256, state RUN.
  - A 257th ld_valid produces no write.
- reload_req in RUN together with fetch_req:
  - Fetch is served that cycle, then one DRAIN cycle with core_hold=1.
  - Then LOAD; the next accepted word is written to LOAD_BASE; load_done=0.
- Deassert reset_n after 3 of 6 words:
  - All outputs take their reset values asynchronously.
  - After release, the first accepted word goes to LOAD_BASE.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/imem_load_controller.sv
// Arbitrates the single-port instruction memory between the boot/debug loader
// and the fetch stage, holding the core in reset while an image is streamed in.
module imem_load_controller
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          fetch_valid,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload_req,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_error,
  output logic [AW:0]   words_loaded,
  output logic [31:0]   mem_byte_address,
  output logic          mem_write_enable,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data
);

  localparam int unsigned CW = AW + 1;

  ctrl_state_t   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
  logic          accept;

  assign accept = ld_valid & ld_ready;

  // Next-state, pointer and counter update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = load_error;
    case (state_q)
      LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + CW'(1);
          if (ld_last) begin
            state_d = RUN;
          end else if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (reload_req) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they track the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      cnt_q      <= '0;
      load_error <= 1'b0;
      core_hold  <= 1'b1;
      ld_ready   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      load_error <= err_d;
      core_hold  <= (state_d != RUN);
      ld_ready   <= (state_d == LOAD);
      load_done  <= (state_d == RUN);
    end
  end

  assign words_loaded = cnt_q;

  // Memory port mux: loader owns the port outside RUN, fetch owns it in RUN.
  always_comb begin
    mem_byte_address = LOAD_BASE + (32'(ptr_q) * 32'(WORD_BYTES));
    mem_write_enable = accept;
    mem_write_data   = ld_data;
    fetch_valid      = 1'b0;
    fetch_data       = NOP_INSTR;
    if (state_q == RUN) begin
      mem_byte_address = fetch_addr;
      mem_write_enable = 1'b0;
      fetch_valid      = fetch_req;
      fetch_data       = mem_read_data;
    end
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller with a behavioural instruction memory.
module tb_imem_load_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload_req;
  logic        core_hold;
  logic        load_done;
  logic        load_error;
  logic [8:0]  words_loaded;
  logic [31:0] mem_byte_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_load_controller dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_data       (fetch_data),
    .fetch_valid      (fetch_valid),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_last          (ld_last),
    .ld_ready         (ld_ready),
    .reload_req       (reload_req),
    .core_hold        (core_hold),
    .load_done        (load_done),
    .load_error       (load_error),
    .words_loaded     (words_loaded),
    .mem_byte_address (mem_byte_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Single-port memory: async read, sync write, word index from address[9:2].
  assign mem_read_data = mem[mem_byte_address[9:2]];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_byte_address[9:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge and sample combinational outputs 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] d, input logic l,
                       input logic fr, input logic [31:0] fa, input logic rr);
    @(negedge clk);
    ld_valid   = v;
    ld_data    = d;
    ld_last    = l;
    fetch_req  = fr;
    fetch_addr = fa;
    reload_req = rr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] prog [6];
  logic        gap  [5];
  int          wr_idx;

  initial begin
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093; prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193; prog[4] = 32'h0040_8213; prog[5] = 32'h0021_82B3;
    gap[0] = 1'b1; gap[1] = 1'b0; gap[2] = 1'b0; gap[3] = 1'b1; gap[4] = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    reset_n = 1'b0;
    ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = 32'h0; reload_req = 1'b0;
    #12;
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_addr", mem_byte_address, 32'h0);
    reset_n = 1'b1;
    idle();
    idle();
    check("ready_after_rst", 32'(ld_ready), 32'd1);

    // Six-word image with ld_last on the final word.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, prog[i], (i == 5), 1'b0, 32'h0, 1'b0);
      check("img_we", 32'(mem_write_enable), 32'd1);
      check("img_addr", mem_byte_address, 32'(i * 4));
      check("img_hold", 32'(core_hold), 32'd1);
    end
    idle();
    check("img_words", 32'(words_loaded), 32'd6);
    check("img_hold_fell", 32'(core_hold), 32'd0);
    check("img_done", 32'(load_done), 32'd1);
    check("img_mem5", mem[5], 32'h0021_82B3);

    // Zero-latency fetch; loader traffic ignored while running.
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h10, 1'b0);
    check("fetch_valid", 32'(fetch_valid), 32'd1);
    check("fetch_data", fetch_data, 32'h0040_8213);
    check("fetch_we", 32'(mem_write_enable), 32'd0);
    check("run_ready", 32'(ld_ready), 32'd0);

    // Reload together with a fetch: fetch served, then one DRAIN cycle.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b1);
    check("rl_fetch_valid", 32'(fetch_valid), 32'd1);
    check("rl_fetch_data", fetch_data, 32'h0010_0093);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    check("drain_hold", 32'(core_hold), 32'd1);
    check("drain_fvalid", 32'(fetch_valid), 32'd0);
    check("drain_ready", 32'(ld_ready), 32'd0);
    idle();
    check("reload_ready", 32'(ld_ready), 32'd1);
    check("reload_done", 32'(load_done), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);
    check("reload_addr", mem_byte_address, 32'h0);
    check("reload_err_kept", 32'(load_error), 32'd0);

    // Gapped loader traffic; reload_req during LOAD is ignored.
    wr_idx = 0;
    for (int i = 0; i < 5; i++) begin
      drive(gap[i], 32'hC000_0000 + 32'(wr_idx), (i == 4), 1'b0, 32'h0, (i == 1));
      check("gap_ready", 32'(ld_ready), 32'd1);
      check("gap_we", 32'(mem_write_enable), 32'(gap[i]));
      if (gap[i]) begin
        check("gap_addr", mem_byte_address, 32'(wr_idx * 4));
        wr_idx++;
      end
    end
    idle();
    check("gap_words", 32'(words_loaded), 32'd3);
    check("gap_mem2", mem[2], 32'hC000_0002);
    check("gap_mem3_old", mem[3], 32'h0030_0193);

    // Overflow: 256 words with no ld_last.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    idle();
    check("ovf_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      if (i == 255) begin
        check("ovf_last_addr", mem_byte_address, 32'h3FC);
        check("ovf_last_we", 32'(mem_write_enable), 32'd1);
      end
    end
    drive(1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ovf_257_we", 32'(mem_write_enable), 32'd0);
    check("ovf_error", 32'(load_error), 32'd1);
    check("ovf_words", 32'(words_loaded), 32'd256);
    check("ovf_run", 32'(load_done), 32'd1);
    check("ovf_hold", 32'(core_hold), 32'd0);
    idle();
    check("ovf_mem255", mem[255], 32'hA000_00FF);
    check("ovf_mem0", mem[0], 32'hA000_0000);

    // Error stays sticky across a reload.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    idle();
    check("err_sticky", 32'(load_error), 32'd1);

    // Reset mid-load after 3 of 6 words.
    for (int i = 0; i < 3; i++) drive(1'b1, prog[i], 1'b0, 1'b0, 32'h0, 1'b0);
    check("mid_addr", mem_byte_address, 32'h8);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hold", 32'(core_hold), 32'd1);
    check("mid_rst_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_we", 32'(mem_write_enable), 32'd0);
    check("mid_rst_err", 32'(load_error), 32'd0);
    check("mid_rst_words", 32'(words_loaded), 32'd0);
    check("mid_rst_addr", mem_byte_address, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
    check("post_rst_we", 32'(mem_write_enable), 32'd1);
    check("post_rst_addr", mem_byte_address, 32'h0);
    idle();
    check("post_rst_mem0", mem[0], 32'h1234_5678);
    check("post_rst_words", 32'(words_loaded), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
